// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported word Memory between the I-cache and
// D-cache miss paths. One requester is granted at a time. Each grant runs a
// burst of BLOCK_WORDS words, and each word (beat) holds the Memory address and
// enable for WORD_LAT cycles. I-cache bursts are reads. D-cache bursts are
// reads or write-backs, selected by dc_we at grant.
//
// Optional feature: define MEM_ARB_RR_EN to grant ties round-robin (to the
// requester that did not win the previous tie). Without it, D beats I on a tie.
//
// Ports:
//   clock, reset (async, active-low)
//   ic_req/ic_addr                    -> I-cache block read request
//   ic_rdata/ic_rvalid/ic_done        <- per-word read data, burst complete
//   dc_req/dc_we/dc_addr/dc_wdata     -> D-cache block request, write word
//   dc_wready                         <- write word consumed (last cycle of beat)
//   dc_rdata/dc_rvalid/dc_done        <- per-word read data, burst complete
//   mem_ren/mem_wen/mem_addr/mem_din  -> Memory controls
//   mem_dout                          <- Memory read data (combinational)
//   busy                              <- burst in progress or completing
module mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_LAT    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_rdata,
  output logic        ic_rvalid,
  output logic        ic_done,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_wready,
  output logic [31:0] dc_rdata,
  output logic        dc_rvalid,
  output logic        dc_done,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int LAT_W  = (WORD_LAT > 1) ? $clog2(WORD_LAT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(WORD_LAT - 1);
  localparam logic [31:0]       ADDR_MASK = ~(32'(BLOCK_WORDS - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner_d;   // 1 = D-cache owns the burst
  logic              r_we;        // burst direction, fixed at grant
  logic [31:0]       r_base;
  logic [BEAT_W-1:0] r_beat;
  logic [LAT_W-1:0]  r_lat;
  logic [31:0]       r_rdata;
  logic              r_ic_rvalid;
  logic              r_dc_rvalid;

  logic w_any_req;
  logic w_grant;
  logic w_grant_d;
  logic w_beat_end;
  logic w_owner_req;

  assign w_any_req   = ic_req | dc_req;
  assign w_grant     = (r_state == S_IDLE) && w_any_req;
  assign w_beat_end  = (r_lat == LAST_LAT);
  assign w_owner_req = r_owner_d ? dc_req : ic_req;

`ifdef MEM_ARB_RR_EN
  // Winner of the most recent tie; a new tie goes to the other requester.
  // Resets to I so the first tie after reset goes to D.
  logic r_last_d;

  assign w_grant_d = dc_req && (!ic_req || !r_last_d);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_d <= 1'b0;
    end else if (w_grant && ic_req && dc_req) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = dc_req;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_BURST;
      S_BURST: if (w_beat_end && (r_beat == LAST_BEAT)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner_d   <= 1'b0;
      r_we        <= 1'b0;
      r_base      <= 32'h0;
      r_beat      <= '0;
      r_lat       <= '0;
      r_rdata     <= 32'h0;
      r_ic_rvalid <= 1'b0;
      r_dc_rvalid <= 1'b0;
    end else begin
      r_ic_rvalid <= 1'b0;
      r_dc_rvalid <= 1'b0;
      if (w_grant) begin
        r_owner_d <= w_grant_d;
        r_we      <= w_grant_d && dc_we;
        r_base    <= (w_grant_d ? dc_addr : ic_addr) & ADDR_MASK;
        r_beat    <= '0;
        r_lat     <= '0;
      end else if (r_state == S_BURST) begin
        if (w_beat_end) begin
          // Beat counter wraps to 0 after the last beat, ready for next grant.
          r_lat  <= '0;
          r_beat <= r_beat + 1'b1;
          if (!r_we) begin
            r_rdata     <= mem_dout;
            r_ic_rvalid <= !r_owner_d;
            r_dc_rvalid <= r_owner_d;
          end
        end else begin
          r_lat <= r_lat + 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 32'h0;
    mem_din   = 32'h0;
    dc_wready = 1'b0;
    if (r_state == S_BURST) begin
      mem_addr = r_base + 32'(r_beat);
      if (r_we) begin
        mem_wen   = 1'b1;
        mem_din   = dc_wdata;
        dc_wready = w_beat_end;
      end else begin
        mem_ren = 1'b1;
      end
    end
  end

  assign ic_done   = (r_state == S_DONE) && !r_owner_d;
  assign dc_done   = (r_state == S_DONE) && r_owner_d;
  assign busy      = (r_state != S_IDLE);
  assign ic_rdata  = r_rdata;
  assign dc_rdata  = r_rdata;
  assign ic_rvalid = r_ic_rvalid;
  assign dc_rvalid = r_dc_rvalid;

`ifndef SYNTHESIS
  // A requester that lets go mid-burst still gets its full burst; flag it.
  logic r_sim_req_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sim_req_q <= 1'b0;
    end else begin
      r_sim_req_q <= w_owner_req;
      if ((r_state == S_BURST) && r_sim_req_q && !w_owner_req) begin
        $display("mem_arbiter warning: %s-cache request dropped mid-burst at %0t",
                 r_owner_d ? "D" : "I", $time);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int BW = 4;
  localparam int WL = 2;
  localparam int N  = BW * WL;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = 32'h0;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = 32'h0;
  logic [31:0] dc_wdata = 32'h0;
  logic        dc_wready;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic        dc_done;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        busy;

  mem_arbiter #(.BLOCK_WORDS(BW), .WORD_LAT(WL)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wready(dc_wready), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
    .dc_done(dc_done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Memory seen by the DUT: unwritten words hold 0x90 + low address byte.
  logic [31:0] mwd [256];
  logic        mwv [256];

  function automatic logic [31:0] dflt(input logic [7:0] a);
    return 32'h90 + {24'h0, a};
  endfunction

  assign mem_dout = (mwv[mem_addr[7:0]] === 1'b1) ? mwd[mem_addr[7:0]] : dflt(mem_addr[7:0]);

  always @(posedge clock) begin
    if (mem_wen) begin
      mwd[mem_addr[7:0]] <= mem_din;
      mwv[mem_addr[7:0]] <= 1'b1;
    end
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return (mwv[b] === 1'b1) ? mwd[b] : dflt(b);
  endfunction

  // D-cache write buffer for the current write-back.
  logic [31:0] wbuf [BW];
  int          widx = 0;

  // Reference model state
  logic [31:0] refd [256];
  bit          refv [256];
  bit          m_act = 1'b0;
  int          m_off = 0;
  bit          m_own_d = 1'b0;
  bit          m_we = 1'b0;
  bit          m_last_d = 1'b0;
  logic [31:0] m_base = 32'h0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return refv[b] ? refd[b] : dflt(b);
  endfunction

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act    = 1'b0;
    m_off    = 0;
    m_last_d = 1'b0;
  endtask

  task automatic model_check();
    logic        e_ren, e_wen, e_wrdy, e_busy, e_icd, e_dcd, e_icv, e_dcv;
    logic [31:0] e_addr, e_din, e_rd;
    int          beat;
    e_ren = 0; e_wen = 0; e_wrdy = 0; e_busy = 0;
    e_icd = 0; e_dcd = 0; e_icv = 0; e_dcv = 0;
    e_addr = 32'h0; e_din = 32'h0; e_rd = 32'h0;
    if (!reset) model_reset();
    if (m_act) begin
      e_busy = 1'b1;
      if (m_off < N) begin
        beat   = m_off / WL;
        e_addr = m_base + 32'(beat);
        e_ren  = !m_we;
        e_wen  = m_we;
        e_din  = m_we ? wbuf[beat] : 32'h0;
        e_wrdy = m_we && ((m_off % WL) == WL - 1);
      end
      if (m_off == N) begin
        e_icd = !m_own_d;
        e_dcd = m_own_d;
      end
      if (!m_we && (m_off >= 1) && ((m_off % WL) == 0)) begin
        e_icv = !m_own_d;
        e_dcv = m_own_d;
        e_rd  = ref_rd(m_base + 32'(m_off / WL - 1));
      end
    end
    chk1("mem_ren", mem_ren, e_ren);
    chk1("mem_wen", mem_wen, e_wen);
    chk1("ren_wen_exclusive", mem_ren & mem_wen, 1'b0);
    chk32("mem_addr", mem_addr, e_addr);
    chk32("mem_din", mem_din, e_din);
    chk1("dc_wready", dc_wready, e_wrdy);
    chk1("busy", busy, e_busy);
    chk1("ic_done", ic_done, e_icd);
    chk1("dc_done", dc_done, e_dcd);
    chk1("ic_rvalid", ic_rvalid, e_icv);
    chk1("dc_rvalid", dc_rvalid, e_dcv);
    if (e_icv) chk32("ic_rdata", ic_rdata, e_rd);
    if (e_dcv) chk32("dc_rdata", dc_rdata, e_rd);
  endtask

  // Called at a posedge with reset high: advance one cycle of the model.
  task automatic model_advance();
    int  beat;
    bit  own;
    if (m_act) begin
      if (m_we && (m_off < N) && ((m_off % WL) == WL - 1)) begin
        beat = m_off / WL;
        refd[8'(m_base + 32'(beat))] = wbuf[beat];
        refv[8'(m_base + 32'(beat))] = 1'b1;
      end
      if (m_off == N) m_act = 1'b0;
      else m_off++;
    end else if (ic_req || dc_req) begin
`ifdef MEM_ARB_RR_EN
      own = dc_req && (!ic_req || !m_last_d);
      if (ic_req && dc_req) m_last_d = own;
`else
      own = dc_req;
`endif
      m_own_d = own;
      m_we    = own && dc_we;
      m_base  = (own ? dc_addr : ic_addr) & ~(32'(BW - 1));
      m_off   = 0;
      m_act   = 1'b1;
    end
  endtask

  // Values sampled at the negedge of the most recent step.
  logic        s_ic_done, s_dc_done, s_ic_rvalid, s_dc_rvalid, s_wready, s_ren;
  logic [31:0] s_ic_rdata, s_dc_rdata, s_addr;
  int          cyc = 0;

  task automatic step();
    @(negedge clock);
    model_check();
    s_ic_done   = ic_done;
    s_dc_done   = dc_done;
    s_ic_rvalid = ic_rvalid;
    s_dc_rvalid = dc_rvalid;
    s_ic_rdata  = ic_rdata;
    s_dc_rdata  = dc_rdata;
    s_wready    = dc_wready;
    s_ren       = mem_ren;
    s_addr      = mem_addr;
    @(posedge clock);
    if (!reset) model_reset();
    else model_advance();
    #1;
    cyc++;
    // Cache-side behaviour: advance write word on wready, release req on done.
    if (s_wready) begin
      widx++;
      dc_wdata = (widx < BW) ? wbuf[widx] : 32'h0;
    end
    if (s_ic_done) ic_req = 1'b0;
    if (s_dc_done) dc_req = 1'b0;
  endtask

  task automatic start_dc(input logic we, input logic [31:0] a);
    dc_we    = we;
    dc_addr  = a;
    widx     = 0;
    dc_wdata = wbuf[0];
    dc_req   = 1'b1;
  endtask

  initial begin
    int          n;
    bit          seen, seen2, first_d;
    int          cnt, d_done_c, i_start_c, i_done_c;
    logic [31:0] dq[$];
    logic [31:0] aq[$];
    logic [31:0] exp_a;

    for (int i = 0; i < 256; i++) refv[i] = 1'b0;
    for (int i = 0; i < BW; i++) wbuf[i] = 32'h0;

    // Reset state
    repeat (3) step();
    chk1("rst_mem_ren", mem_ren, 1'b0);
    chk1("rst_mem_wen", mem_wen, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ic_done", ic_done, 1'b0);
    chk1("rst_dc_rvalid", dc_rvalid, 1'b0);
    chk32("rst_ic_rdata", ic_rdata, 32'h0);
    reset = 1'b1;
    step();

    // I read of block 0x10..0x13
    ic_addr = 32'h13;
    ic_req  = 1'b1;
    n = 0; seen = 0;
    dq.delete(); aq.delete();
    while (!seen && n < 40) begin
      step(); n++;
      if (s_ren) aq.push_back(s_addr);
      if (s_ic_rvalid) dq.push_back(s_ic_rdata);
      if (s_ic_done) seen = 1;
    end
    chk1("t1_done_seen", seen, 1'b1);
    // Step 1 contains the grant edge; done follows 9 cycles after it.
    chk32("t1_done_latency", 32'(n - 1), 32'd9);
    chk32("t1_rvalid_count", 32'(dq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk32("t1_rdata", (i < dq.size()) ? dq[i] : 32'hDEAD, 32'hA0 + 32'(i));
    chk32("t1_ren_cycles", 32'(aq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk32("t1_mem_addr", (i < aq.size()) ? aq[i] : 32'hDEAD, 32'h10 + 32'(i / 2));
    step();

    // D write-back to 0x20..0x23
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    start_dc(1'b1, 32'h20);
    n = 0; seen = 0; cnt = 0; seen2 = 0;
    while (!seen && n < 40) begin
      step(); n++;
      if (s_wready) cnt++;
      if (s_ren) seen2 = 1;
      if (s_dc_done) seen = 1;
    end
    chk1("t2_done_seen", seen, 1'b1);
    chk32("t2_wready_count", 32'(cnt), 32'd4);
    chk1("t2_ren_never", seen2, 1'b0);
    chk32("t2_mem20", mem_rd(32'h20), 32'h11);
    chk32("t2_mem21", mem_rd(32'h21), 32'h22);
    chk32("t2_mem22", mem_rd(32'h22), 32'h33);
    chk32("t2_mem23", mem_rd(32'h23), 32'h44);
    step();

    // Tie: both requests on the same edge
    ic_addr = 32'h30;
    start_dc(1'b0, 32'h50);
    ic_req = 1'b1;
    n = 0; d_done_c = -1; i_start_c = -1; i_done_c = -1;
    while (i_done_c < 0 && n < 60) begin
      step(); n++;
      if (s_dc_done && d_done_c < 0) d_done_c = n;
      if (s_ren && s_addr == 32'h30 && i_start_c < 0) i_start_c = n;
      if (s_ic_done) i_done_c = n;
    end
    chk1("t3_both_done", (d_done_c > 0) && (i_done_c > 0), 1'b1);
    chk1("t3_d_first", d_done_c < i_done_c, 1'b1);
    chk32("t3_idle_gap", 32'(i_start_c - d_done_c), 32'd2);

    // Second tie
    ic_addr = 32'h38;
    start_dc(1'b0, 32'h58);
    ic_req = 1'b1;
    n = 0; seen = 0; first_d = 0;
    while (!seen && n < 40) begin
      step(); n++;
      if (s_ic_done || s_dc_done) begin seen = 1; first_d = s_dc_done; end
    end
    chk1("t3_second_tie_done", seen, 1'b1);
`ifdef MEM_ARB_RR_EN
    chk1("t3_second_tie_owner_d", first_d, 1'b0);
`else
    chk1("t3_second_tie_owner_d", first_d, 1'b1);
`endif
    n = 0;
    while ((ic_req || dc_req) && n < 40) begin step(); n++; end
    chk1("t3_drained", ic_req | dc_req, 1'b0);
    step();

    // Reset during beat 2 of a D read
    start_dc(1'b0, 32'h40);
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      step(); n++;
      if (s_ren && s_addr == 32'h42) seen = 1;
    end
    chk1("t4_beat2_reached", seen, 1'b1);
    reset  = 1'b0;
    dc_req = 1'b0;
    #1;
    chk1("t4_rst_ren", mem_ren, 1'b0);
    chk32("t4_rst_addr", mem_addr, 32'h0);
    chk1("t4_rst_busy", busy, 1'b0);
    chk1("t4_rst_dc_rvalid", dc_rvalid, 1'b0);
    chk32("t4_rst_dc_rdata", dc_rdata, 32'h0);
    repeat (2) step();
    reset   = 1'b1;
    ic_addr = 32'h45;
    ic_req  = 1'b1;
    n = 0; seen = 0; exp_a = 32'hDEAD;
    while (!seen && n < 40) begin
      step(); n++;
      if (s_ren && exp_a == 32'hDEAD) exp_a = s_addr;
      if (s_ic_done) seen = 1;
    end
    chk1("t4_restart_done", seen, 1'b1);
    chk32("t4_restart_first_addr", exp_a, 32'h44);
    step();

    // D read with request dropped after the first beat
    start_dc(1'b0, 32'h60);
    n = 0; seen = 0; cnt = 0;
    while (!s_ren && n < 10) begin step(); n++; end
    step(); step();
    dc_req = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      step(); n++;
      if (s_dc_rvalid) cnt++;
      if (s_dc_done) seen = 1;
    end
    chk1("t5_done_after_drop", seen, 1'b1);
    // The first beat's word returns inside the two steps before the drop.
    chk32("t5_rvalid_after_drop", 32'(cnt), 32'd3);
    step();

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      if (!ic_req && $urandom_range(0, 3) == 0) begin
        ic_addr = 32'($urandom_range(0, 255));
        ic_req  = 1'b1;
      end else if (ic_req && $urandom_range(0, 7) == 0) begin
        ic_addr = 32'($urandom_range(0, 255));
      end
      if (!dc_req && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < BW; i++) wbuf[i] = $urandom;
        start_dc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)));
      end else if (dc_req && $urandom_range(0, 7) == 0) begin
        dc_addr = 32'($urandom_range(0, 255));
      end
      step();
    end
    n = 0;
    while ((ic_req || dc_req) && n < 60) begin step(); n++; end
    chk1("rand_drained", ic_req | dc_req, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
